// File: rtl/rx_global_ctrl_ml.sv
// Receive-side LP/HS control: LP line synchronisation and filtering, clock and data lane
// state machines, lane-aligner sync qualification and sync timeout.
module rx_global_ctrl_ml #(
    parameter int NUM_DLANES   = 4,
    parameter int LP_FILT      = 2,
    parameter int T_CLK_SETTLE = 8,
    parameter int T_HS_SETTLE  = 6,
    parameter int CONT_CLK     = 0,
    parameter int SYNC_TMO     = 1023
) (
    input  logic                    clk_lp_ctrl_i,
    input  logic                    reset_lp_i,
    input  logic                    lp_clk_p_i,
    input  logic                    lp_clk_n_i,
    input  logic [NUM_DLANES-1:0]   lp_d_p_i,
    input  logic [NUM_DLANES-1:0]   lp_d_n_i,
    input  logic                    hs_sync_i,
    output logic                    term_clk_en_o,
    output logic [NUM_DLANES-1:0]   term_d_en_o,
    output logic [NUM_DLANES-1:0]   hs_d_en_o,
    output logic                    hs_sync_o,
    output logic                    sync_err_o,
    output logic [NUM_DLANES-1:0]   lp_err_o,
    output logic [1:0]              lp_hs_state_clk_o,
    output logic [2*NUM_DLANES-1:0] lp_hs_state_d_o
);

    localparam logic [1:0] ST_STOP    = 2'b00;
    localparam logic [1:0] ST_HS_RQST = 2'b01;
    localparam logic [1:0] ST_SETTLE  = 2'b10;
    localparam logic [1:0] ST_HS      = 2'b11;

    localparam logic [1:0] LP00 = 2'b00;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP10 = 2'b10;
    localparam logic [1:0] LP11 = 2'b11;

    // Line index map: 0/1 = clock P/N, 2+2k/3+2k = data lane k P/N.
    localparam int NL = 2 + 2 * NUM_DLANES;

    logic [NL-1:0]                  lp_raw, lp_meta, lp_sync, lp_filt;
    logic [NL-1:0][3:0]             filt_cnt;
    logic [1:0]                     clk_lp, clk_state;
    logic [7:0]                     clk_cnt;
    logic [NUM_DLANES-1:0][1:0]     d_lp, d_state;
    logic [NUM_DLANES-1:0][7:0]     d_cnt;
    logic [NUM_DLANES-1:0]          lane_err;
    logic                           all_hs, sync_seen, counting, tmo_hit;
    logic [15:0]                    sync_tmr;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        lp_raw    = '0;
        lp_raw[0] = lp_clk_p_i;
        lp_raw[1] = lp_clk_n_i;
        for (int k = 0; k < NUM_DLANES; k++) begin
            lp_raw[2+2*k] = lp_d_p_i[k];
            lp_raw[3+2*k] = lp_d_n_i[k];
        end
    end

    always_ff @(posedge clk_lp_ctrl_i) begin
        if (reset_lp_i) begin
            lp_meta  <= '1;
            lp_sync  <= '1;
            lp_filt  <= '1;
            filt_cnt <= '0;
        end else begin
            // NOTE: state registers use non-blocking '<=' so all flops update from pre-edge values.
            lp_meta <= lp_raw;
            lp_sync <= lp_meta;
            for (int i = 0; i < NL; i++) begin
                if (lp_sync[i] == lp_filt[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == 4'(LP_FILT - 1)) begin
                    lp_filt[i]  <= lp_sync[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        clk_lp   = {lp_filt[0], lp_filt[1]};
        d_lp     = '0;
        lane_err = '0;
        for (int k = 0; k < NUM_DLANES; k++) begin
            d_lp[k]     = {lp_filt[2+2*k], lp_filt[3+2*k]};
            lane_err[k] = ((d_state[k] == ST_HS_RQST) && (d_lp[k] == LP10)) ||
                          ((d_state[k] == ST_SETTLE) && ((d_lp[k] == LP01) || (d_lp[k] == LP10)));
        end
    end

    always_ff @(posedge clk_lp_ctrl_i) begin
        if (reset_lp_i) begin
            clk_state <= (CONT_CLK != 0) ? ST_HS : ST_STOP;
            clk_cnt   <= '0;
        end else if (CONT_CLK != 0) begin
            clk_state <= ST_HS;
        end else begin
            case (clk_state)
                ST_STOP:    if (clk_lp == LP01) clk_state <= ST_HS_RQST;
                ST_HS_RQST: begin
                    if (clk_lp == LP00) begin
                        clk_state <= ST_SETTLE;
                        clk_cnt   <= '0;
                    end else if (clk_lp[1]) begin
                        clk_state <= ST_STOP;
                    end
                end
                ST_SETTLE: begin
                    // LP11 wins over a settle counter expiring in the same cycle.
                    if (clk_lp == LP11)                         clk_state <= ST_STOP;
                    else if (clk_cnt == 8'(T_CLK_SETTLE - 1))   clk_state <= ST_HS;
                    else                                        clk_cnt   <= clk_cnt + 8'd1;
                end
                default:    if (clk_lp == LP11) clk_state <= ST_STOP;
            endcase
        end
    end

    always_ff @(posedge clk_lp_ctrl_i) begin
        if (reset_lp_i) begin
            d_state  <= '0;
            d_cnt    <= '0;
            lp_err_o <= '0;
        end else begin
            for (int k = 0; k < NUM_DLANES; k++) begin
                lp_err_o[k] <= lane_err[k];
                if ((clk_state != ST_HS) || tmo_hit || lane_err[k]) begin
                    d_state[k] <= ST_STOP;
                end else begin
                    case (d_state[k])
                        ST_STOP:    if (d_lp[k] == LP01) d_state[k] <= ST_HS_RQST;
                        ST_HS_RQST: begin
                            if (d_lp[k] == LP00) begin
                                d_state[k] <= ST_SETTLE;
                                d_cnt[k]   <= '0;
                            end else if (d_lp[k] == LP11) begin
                                d_state[k] <= ST_STOP;
                            end
                        end
                        ST_SETTLE: begin
                            if (d_lp[k] == LP11)                      d_state[k] <= ST_STOP;
                            else if (d_cnt[k] == 8'(T_HS_SETTLE - 1)) d_state[k] <= ST_HS;
                            else                                      d_cnt[k]   <= d_cnt[k] + 8'd1;
                        end
                        default:    if (d_lp[k] == LP11) d_state[k] <= ST_STOP;
                    endcase
                end
            end
        end
    end

    // The timer runs only while the whole burst is in HS and no sync has been seen yet.
    assign all_hs   = &hs_d_en_o;
    assign counting = all_hs && !sync_seen && !hs_sync_i;
    assign tmo_hit  = counting && (sync_tmr == 16'(SYNC_TMO - 1));

    always_ff @(posedge clk_lp_ctrl_i) begin
        if (reset_lp_i) begin
            hs_sync_o  <= 1'b0;
            sync_err_o <= 1'b0;
            sync_seen  <= 1'b0;
            sync_tmr   <= '0;
        end else begin
            hs_sync_o  <= hs_sync_i && all_hs;
            sync_err_o <= tmo_hit;
            if (!all_hs) begin
                sync_seen <= 1'b0;
                sync_tmr  <= '0;
            end else begin
                if (hs_sync_i) sync_seen <= 1'b1;
                if (counting && (sync_tmr != 16'hFFFF)) sync_tmr <= sync_tmr + 16'd1;
            end
        end
    end

    always_comb begin
        term_clk_en_o     = clk_state[1];
        lp_hs_state_clk_o = clk_state;
        lp_hs_state_d_o   = d_state;
        term_d_en_o       = '0;
        hs_d_en_o         = '0;
        for (int k = 0; k < NUM_DLANES; k++) begin
            term_d_en_o[k] = d_state[k][1];
            hs_d_en_o[k]   = &d_state[k];
        end
    end

endmodule

// File: tb/tb_rx_global_ctrl_ml.sv
// Bench for rx_global_ctrl_ml: directed scenarios plus randomized per-lane LP sequences whose
// outcomes are predicted from the lane protocol rules.
module tb_rx_global_ctrl_ml;

    localparam int LP_FILT      = 2;
    localparam int T_CLK_SETTLE = 8;
    localparam int T_HS_SETTLE  = 6;
    localparam int SYNC_TMO     = 1023;
    localparam int B_LP_FILT    = 3;
    // Edge that first samples a line change, then 2 sync flops and the filter, then the FSM.
    localparam int A_LAT = 3 + LP_FILT;
    localparam int B_LAT = 3 + B_LP_FILT;

    localparam logic [1:0] LP00 = 2'b00;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP10 = 2'b10;
    localparam logic [1:0] LP11 = 2'b11;

    typedef enum int {ACT_NORMAL, ACT_ABORT, ACT_ERR_RQ, ACT_ERR_SETTLE, ACT_IDLE} act_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, a_clk_p, a_clk_n, a_sync;
    logic [3:0] a_dp, a_dn;
    logic       a_term_clk, a_hs_sync, a_sync_err;
    logic [3:0] a_term_d, a_hs_d, a_lp_err;
    logic [1:0] a_st_clk;
    logic [7:0] a_st_d;

    logic       rst_b, b_clk_p, b_clk_n, b_sync;
    logic [0:0] b_dp, b_dn;
    logic       b_term_clk, b_hs_sync, b_sync_err;
    logic [0:0] b_term_d, b_hs_d, b_lp_err;
    logic [1:0] b_st_clk;
    logic [1:0] b_st_d;

    rx_global_ctrl_ml dut_a (
        .clk_lp_ctrl_i(clk), .reset_lp_i(rst_a),
        .lp_clk_p_i(a_clk_p), .lp_clk_n_i(a_clk_n), .lp_d_p_i(a_dp), .lp_d_n_i(a_dn),
        .hs_sync_i(a_sync), .term_clk_en_o(a_term_clk), .term_d_en_o(a_term_d),
        .hs_d_en_o(a_hs_d), .hs_sync_o(a_hs_sync), .sync_err_o(a_sync_err),
        .lp_err_o(a_lp_err), .lp_hs_state_clk_o(a_st_clk), .lp_hs_state_d_o(a_st_d)
    );

    rx_global_ctrl_ml #(.NUM_DLANES(1), .LP_FILT(B_LP_FILT), .CONT_CLK(1)) dut_b (
        .clk_lp_ctrl_i(clk), .reset_lp_i(rst_b),
        .lp_clk_p_i(b_clk_p), .lp_clk_n_i(b_clk_n), .lp_d_p_i(b_dp), .lp_d_n_i(b_dn),
        .hs_sync_i(b_sync), .term_clk_en_o(b_term_clk), .term_d_en_o(b_term_d),
        .hs_d_en_o(b_hs_d), .hs_sync_o(b_hs_sync), .sync_err_o(b_sync_err),
        .lp_err_o(b_lp_err), .lp_hs_state_clk_o(b_st_clk), .lp_hs_state_d_o(b_st_d)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int err_cycles [4];
    int serr_cycles = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge(s), tallying pulse cycles on dut_a.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) if (a_lp_err[k]) err_cycles[k]++;
            if (a_sync_err) serr_cycles++;
        end
    endtask

    task automatic set_lane(input int k, input logic [1:0] lp);
        a_dp[k] = lp[1];
        a_dn[k] = lp[0];
    endtask

    task automatic set_all(input logic [1:0] lp);
        for (int k = 0; k < 4; k++) set_lane(k, lp);
    endtask

    task automatic set_clk(input logic [1:0] lp);
        a_clk_p = lp[1];
        a_clk_n = lp[0];
    endtask

    initial begin
        int         lat;
        logic       seen;
        act_t       act [4];
        int         err0 [4];
        logic [7:0] exp_st;
        logic [3:0] exp_hs;
        logic [31:0] exp_err, obs_err;

        for (int k = 0; k < 4; k++) err_cycles[k] = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        a_sync = 1'b0; b_sync = 1'b0;
        set_clk(LP11); set_all(LP11);
        b_clk_p = 1'b1; b_clk_n = 1'b1; b_dp = 1'b1; b_dn = 1'b1;
        tick(3);
        check("a_reset_outputs", {a_term_clk, a_st_clk, a_term_d, a_hs_d, a_hs_sync,
                                  a_sync_err, a_lp_err, a_st_d}, 32'd0);
        check("b_reset_outputs", {b_term_clk, b_st_clk, b_term_d, b_hs_d, b_hs_sync,
                                  b_sync_err, b_lp_err, b_st_d}, {22'd0, 1'b1, 2'b11, 7'd0});
        rst_a = 1'b0; rst_b = 1'b0;

        // Clock lane: LP11 -> LP01 -> LP00, then settle into HS.
        set_clk(LP01);
        tick(8);
        check("clk_hs_rqst", a_st_clk, 2'b01);
        set_clk(LP00);
        lat = 0;
        while (lat < 40) begin tick(1); lat++; if (a_term_clk) break; end
        check("clk_term_latency", lat, A_LAT);
        check("clk_settle_state", a_st_clk, 2'b10);
        lat = 0;
        while (lat < 40) begin tick(1); lat++; if (a_st_clk == 2'b11) break; end
        check("clk_settle_cycles", lat, T_CLK_SETTLE);

        // All data lanes into HS, then a qualified sync pulse.
        set_all(LP01);
        tick(8);
        check("d_hs_rqst", a_st_d, 8'h55);
        set_all(LP00);
        lat = 0;
        while (lat < 40) begin tick(1); lat++; if (a_hs_d == 4'hF) break; end
        check("d_hs_latency", lat, A_LAT + T_HS_SETTLE);
        check("d_term_en", a_term_d, 4'hF);
        tick(20);
        a_sync = 1'b1;
        check("sync_before", a_hs_sync, 1'b0);
        tick(1);
        a_sync = 1'b0;
        check("sync_out_pulse", a_hs_sync, 1'b1);
        tick(1);
        check("sync_out_end", a_hs_sync, 1'b0);
        tick(1100);
        check("sync_seen_no_tmo", {a_hs_d, 28'(serr_cycles)}, {4'hF, 28'd0});

        // New burst without sync: timeout after SYNC_TMO cycles in HS.
        set_all(LP11);
        tick(8);
        check("d_stop", a_st_d, 8'h00);
        set_all(LP01);
        tick(8);
        set_all(LP00);
        lat = 0;
        while (lat < 40) begin tick(1); lat++; if (a_hs_d == 4'hF) break; end
        check("d_hs_latency2", lat, A_LAT + T_HS_SETTLE);
        lat = 0;
        while (lat < 2000) begin tick(1); lat++; if (a_sync_err) break; end
        check("sync_tmo_cycles", lat, SYNC_TMO);
        check("sync_tmo_stop", {a_hs_d, a_st_d}, 12'd0);
        tick(50);
        check("sync_err_once", serr_cycles, 1);

        // Randomized per-lane LP sequences; iteration 0 is lane 2 erring in HS_RQST.
        set_all(LP11);
        tick(8);
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < 4; k++) begin
                if (it == 0) act[k] = (k == 2) ? ACT_ERR_RQ : ACT_NORMAL;
                else         act[k] = act_t'($urandom_range(0, 4));
                err0[k] = err_cycles[k];
            end
            for (int k = 0; k < 4; k++) set_lane(k, (act[k] == ACT_IDLE) ? LP11 : LP01);
            tick(8);
            exp_st = '0;
            for (int k = 0; k < 4; k++) if (act[k] != ACT_IDLE) exp_st[2*k +: 2] = 2'b01;
            check($sformatf("rnd%0d_rqst", it), a_st_d, exp_st);
            for (int k = 0; k < 4; k++) begin
                case (act[k])
                    ACT_NORMAL, ACT_ERR_SETTLE: set_lane(k, LP00);
                    ACT_ERR_RQ:                 set_lane(k, LP10);
                    default:                    set_lane(k, LP11);
                endcase
            end
            tick(4);
            for (int k = 0; k < 4; k++) if (act[k] == ACT_ERR_SETTLE) set_lane(k, LP10);
            tick(12);
            exp_st = '0; exp_hs = '0; exp_err = '0; obs_err = '0;
            for (int k = 0; k < 4; k++) begin
                if (act[k] == ACT_NORMAL) begin
                    exp_st[2*k +: 2] = 2'b11;
                    exp_hs[k]        = 1'b1;
                end
                if (act[k] == ACT_ERR_RQ || act[k] == ACT_ERR_SETTLE) exp_err[8*k +: 8] = 8'd1;
                obs_err[8*k +: 8] = 8'(err_cycles[k] - err0[k]);
            end
            check($sformatf("rnd%0d_state", it), a_st_d, exp_st);
            check($sformatf("rnd%0d_hs_en", it), {a_hs_d, a_term_d}, {exp_hs, exp_hs});
            check($sformatf("rnd%0d_err_cycles", it), obs_err, exp_err);
            set_all(LP11);
            tick(8);
            check($sformatf("rnd%0d_stop", it), a_st_d, 8'h00);
        end

        // Settle expiry coinciding with LP11 goes to STOP; one cycle later it reaches HS first.
        for (int v = 0; v < 2; v++) begin
            set_all(LP01);
            tick(8);
            set_all(LP00);
            tick(T_HS_SETTLE + v);
            set_all(LP11);
            seen = 1'b0;
            repeat (12) begin tick(1); seen |= |a_hs_d; end
            check($sformatf("settle_vs_lp11_%0d", v), {seen, a_st_d}, {(v == 1), 8'h00});
        end

        // Clock lane leaving HS drops every data lane one cycle later.
        set_all(LP01);
        tick(8);
        set_all(LP00);
        tick(14);
        check("pre_clk_drop", a_hs_d, 4'hF);
        set_clk(LP11);
        tick(A_LAT);
        check("clk_drop_state", {a_st_clk, a_hs_d}, {2'b00, 4'hF});
        tick(1);
        check("clk_drop_data", {a_hs_d, a_st_d}, 12'd0);

        // Reset in the middle of a burst with sync asserted.
        set_clk(LP01);
        tick(8);
        set_clk(LP00);
        tick(A_LAT + T_CLK_SETTLE + 1);
        check("clk_hs_again", a_st_clk, 2'b11);
        set_all(LP01);
        tick(8);
        set_all(LP00);
        tick(14);
        a_sync = 1'b1;
        tick(1);
        check("burst_sync", {a_hs_d, a_hs_sync}, {4'hF, 1'b1});
        rst_a = 1'b1;
        tick(1);
        check("mid_reset_1", {a_term_clk, a_st_clk, a_term_d, a_hs_d, a_hs_sync,
                              a_sync_err, a_lp_err, a_st_d}, 32'd0);
        tick(2);
        check("mid_reset_3", {a_term_clk, a_st_clk, a_term_d, a_hs_d, a_hs_sync,
                              a_sync_err, a_lp_err, a_st_d}, 32'd0);
        a_sync = 1'b0;
        rst_a  = 1'b0;
        seen   = 1'b0;
        repeat (20) begin
            tick(1);
            seen |= a_term_clk | a_hs_sync | a_sync_err | (|a_lp_err) | (|a_hs_d);
        end
        check("post_reset_quiet", seen, 1'b0);

        // Continuous clock, one lane, LP_FILT=3: clock lines held LP11 must be ignored.
        check("b_cont_clk", {b_term_clk, b_st_clk}, 3'b111);
        b_dp = 1'b0; b_dn = 1'b0;
        seen = 1'b0;
        repeat (2) begin tick(1); seen |= (b_st_d != 2'b00); end
        b_dp = 1'b1; b_dn = 1'b1;
        repeat (12) begin tick(1); seen |= (b_st_d != 2'b00); end
        check("b_glitch_lp00", seen, 1'b0);
        b_dp = 1'b0;
        repeat (2) begin tick(1); seen |= (b_st_d != 2'b00); end
        b_dp = 1'b1;
        repeat (12) begin tick(1); seen |= (b_st_d != 2'b00); end
        check("b_glitch_lp01", seen, 1'b0);
        b_dp = 1'b0;
        lat = 0;
        while (lat < 40) begin tick(1); lat++; if (b_st_d == 2'b01) break; end
        check("b_rqst_latency", lat, B_LAT);
        b_dn = 1'b0;
        lat = 0;
        while (lat < 40) begin tick(1); lat++; if (b_hs_d == 1'b1) break; end
        check("b_hs_latency", lat, B_LAT + T_HS_SETTLE);
        check("b_hs_state", {b_term_d, b_st_d, b_term_clk, b_st_clk}, 6'b1_11_1_11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
